// File: rtl/rnn_step_ctrl.sv
// rnn_step_ctrl: sequences stream words into the rnn slot file, with optional hidden-state recurrence.
module rnn_step_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int RECUR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  num_steps,
  input  logic [31:0] h_init,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [2:0]  rnn_sel,
  output logic [31:0] rnn_in,
  input  logic [31:0] rnn_out,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, HLOAD, LOAD, SETTLE, EMIT, DONE} state_t;
  localparam state_t FIRST = (RECUR != 0) ? HLOAD : LOAD;
  localparam logic [2:0] LAST = (RECUR != 0) ? 3'd6 : 3'd7;
  state_t state, nxt;
  logic [2:0] slot, park_sel;
  logic [3:0] cnt;
  logic [7:0] steps_left;
  logic [31:0] h, res, park_word;
  logic settled;
  assign settled = cnt == 4'(SETTLE_CYCLES);
  // rnn writes every clock, so the registered outputs simply hold the last write when parked
  assign rnn_sel = park_sel;
  assign rnn_in = park_word;
  assign out_data = res;
  assign in_ready = state == LOAD;
  assign out_valid = state == EMIT;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = (num_steps == 8'd0) ? DONE : FIRST;
      HLOAD:   nxt = LOAD;
      LOAD:    if (in_valid && slot == LAST) nxt = SETTLE;
      SETTLE:  if (settled) nxt = EMIT;
      EMIT:    if (out_ready) nxt = (steps_left > 8'd1) ? FIRST : DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      slot <= '0;
      cnt <= '0;
      steps_left <= '0;
      h <= '0;
      res <= '0;
      park_sel <= '0;
      park_word <= '0;
    end else begin
      state <= nxt;
      slot <= (state == LOAD) ? slot + {2'b0, in_valid} : 3'd0;
      cnt <= (state == SETTLE) ? cnt + 4'd1 : 4'd0;
      if (state == IDLE && start) begin
        steps_left <= num_steps;
        h <= h_init;
      end
      if (state == HLOAD) begin
        park_sel <= 3'd7;
        park_word <= h;
      end
      if (state == LOAD && in_valid) begin
        park_sel <= slot;
        park_word <= in_data;
      end
      if (state == SETTLE && settled) begin
        res <= rnn_out;
        h <= rnn_out;
      end
      if (state == EMIT && out_ready) steps_left <= steps_left - 8'd1;
    end
  end
endmodule

// File: tb/tb_rnn_step_ctrl.sv
// tb_rnn_step_ctrl: directed bench driving rnn_step_ctrl against a summing slot-file stub.
module tb_rnn_step_ctrl;
  logic clk = 0, rst_n = 0, start = 1, in_valid = 0, out_ready = 1;
  logic [7:0] num_steps = 0;
  logic [31:0] h_init = 0, in_data = 0, rnn_in, rnn_out, out_data;
  logic [2:0] rnn_sel;
  logic in_ready, out_valid, busy, done;
  logic [31:0] slots [8] = '{default: 0};
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  rnn_step_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_steps(num_steps), .h_init(h_init),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .rnn_sel(rnn_sel),
    .rnn_in(rnn_in), .rnn_out(rnn_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  // stub of the rnn slot file: unconditional write, output is the wrapping sum of all slots
  always @(posedge clk) slots[rnn_sel] <= rnn_in;
  always_comb begin
    rnn_out = '0;
    for (int i = 0; i < 8; i++) rnn_out = rnn_out + slots[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [31:0] base, input logic [31:0] inc, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      in_data = base + i * inc;
      if (gaps) begin
        in_valid = 0;
        @(negedge clk);
      end
      in_valid = 1;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("in_ready", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_ov(input string tag, input logic [31:0] exp);
    int t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp);
  endtask

  initial begin
    int dn, ov;
    logic [31:0] held;
    // reset held with start asserted
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_sel", rnn_sel, 0);
    chk("rst_in", rnn_in, 0);
    rst_n = 1;
    start = 0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // single step with exact latency
    start = 1; num_steps = 1; h_init = 100;
    @(negedge clk);
    start = 0;
    chk("s1_busy", busy, 1);
    chk("s1_hload_ready", in_ready, 0);
    feed(1, 1, 7, 0);
    chk("s1_lat_c1", out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    chk("s1_lat_c3", out_valid, 0);
    @(negedge clk);
    chk("s1_lat_c4", out_valid, 1);
    chk("s1_data", out_data, 128);
    @(negedge clk);
    chk("s1_done", done, 1);
    chk("s1_no_ov", out_valid, 0);
    @(negedge clk);
    chk("s1_done_low", done, 0);
    chk("s1_idle", busy, 0);

    // recurrence over three steps
    start = 1; num_steps = 3; h_init = 0;
    @(negedge clk);
    start = 0;
    for (int s = 0; s < 3; s++) begin
      wait_ready();
      chk("rec_h_sel", rnn_sel, 7);
      chk("rec_h_val", rnn_in, 7 * s);
      feed(1, 0, 7, 0);
      wait_ov("rec", 7 * (s + 1));
      @(negedge clk);
    end
    chk("rec_done", done, 1);
    @(negedge clk);

    // gaps on the input and a 10-cycle output stall
    out_ready = 0;
    start = 1; num_steps = 2; h_init = 10;
    @(negedge clk);
    start = 0;
    feed(2, 2, 7, 1);
    wait_ov("bp1", 66);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stable", out_data, held);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    for (int i = 0; i < 7; i++) chk("bp_slot", slots[i], 2 * (i + 1));
    chk("bp_slot7", slots[7], 10);
    chk("bp_rnn_out", rnn_out, 66);
    out_ready = 1;
    @(negedge clk);
    feed(2, 2, 7, 1);
    wait_ov("bp2", 122);
    @(negedge clk);
    chk("bp_done", done, 1);
    @(negedge clk);

    // zero steps, plus a start issued while busy
    start = 1; num_steps = 0;
    @(negedge clk);
    num_steps = 5;
    chk("z_busy", busy, 1);
    dn = done; ov = out_valid;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 4; i++) begin
      dn += done; ov += out_valid;
      @(negedge clk);
    end
    chk("z_done_count", dn, 1);
    chk("z_no_ov", ov, 0);
    chk("z_ignored", busy, 0);

    // reset part way through step 2, then a fresh sequence
    start = 1; num_steps = 3; h_init = 0;
    @(negedge clk);
    start = 0;
    feed(1, 0, 7, 0);
    wait_ov("mr1", 7);
    @(negedge clk);
    wait_ready();
    feed(1, 0, 4, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mr_busy", busy, 0);
    chk("mr_ready", in_ready, 0);
    chk("mr_sel", rnn_sel, 0);
    dn = 0; ov = 0;
    for (int i = 0; i < 6; i++) begin
      dn += done; ov += out_valid;
      @(negedge clk);
    end
    chk("mr_no_done", dn, 0);
    chk("mr_no_ov", ov, 0);
    start = 1; num_steps = 1; h_init = 5;
    @(negedge clk);
    start = 0;
    feed(1, 1, 7, 0);
    wait_ov("mr2", 33);
    @(negedge clk);
    chk("mr2_done", done, 1);
    @(negedge clk);
    chk("mr2_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
